// File: rtl/seq_mult_param.sv
// seq_mult_param: parameterised shift-add sequential multiplier.
//   Accepts one operation at a time through a start/busy/done handshake.
//   Latency is WIDTH+1 cycles after the accepting edge, independent of operand values.
//   The product is held stable on result until the next accepted start.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   signed_mode  1: two's complement operands/result, 0: unsigned
//   A_in, B_in   WIDTH-bit multiplicand / multiplier, latched on accept
//   busy         operation in progress
//   done         result valid (level), cleared on the next accepted start
//   result       2*WIDTH-bit product
module seq_mult_param #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic               sign;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Magnitude of a two's complement value. -2^(W-1) maps to 2^(W-1), which
  // still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // Upper WIDTH+1 bits of acc hold the running partial sum; the carry bit
  // keeps the add lossless before the right shift.
  always_comb begin
    sum  = acc[2*WIDTH:WIDTH] + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    prod = acc[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sign   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign   <= signed_mode & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
            mcand  <= signed_mode ? mag(A_in) : A_in;
            mplier <= signed_mode ? mag(B_in) : B_in;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= {1'b0, sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          // Zero product skips the negate so a zero never picks up a sign.
          result <= (sign && (prod != '0)) ? (~prod + 1'b1) : prod;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4 = 0, sm4 = 0;
  logic [3:0]  a4 = 0, b4 = 0;
  logic        busy4, done4;
  logic [7:0]  res4;

  logic        start8 = 0, sm8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8;
  logic [15:0] res8;

  seq_mult_param #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .A_in(a4), .B_in(b4), .busy(busy4), .done(done4), .result(res4));

  seq_mult_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .A_in(a8), .B_in(b8), .busy(busy8), .done(done8), .result(res8));

  int checks = 0;
  int errors = 0;

  logic [15:0] q4[$];
  logic [15:0] q8[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
  function automatic logic [15:0] model(input int w, input bit sm, input int a, input int b);
    longint sa, sb, p;
    sa = a; sb = b;
    if (sm) begin
      if (a >= (1 << (w - 1))) sa = a - (1 << w);
      if (b >= (1 << (w - 1))) sb = b - (1 << w);
    end
    p = (sa * sb) & ((64'd1 << (2 * w)) - 1);
    return p[15:0];
  endfunction

  // Monitor: pops the scoreboard on each rising done, checks result hold.
  logic        d4q = 0, d8q = 0;
  logic [7:0]  r4q = 0;
  logic [15:0] r8q = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done4 && !d4q) begin
        if (q4.size() == 0) chk("w4_unexpected_done", 16'h1, 16'h0);
        else chk("w4_result", {8'h0, res4}, q4.pop_front());
      end
      if (done4 && d4q) chk("w4_hold", {8'h0, res4}, {8'h0, r4q});
      if (done8 && !d8q) begin
        if (q8.size() == 0) chk("w8_unexpected_done", 16'h1, 16'h0);
        else chk("w8_result", res8, q8.pop_front());
      end
      if (done8 && d8q) chk("w8_hold", res8, r8q);
    end
    d4q = rst ? 1'b0 : done4;  r4q = res4;
    d8q = rst ? 1'b0 : done8;  r8q = res8;
  end

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction

  // One operation: wait idle, pulse start, check busy and exact latency.
  task automatic op(input bit w8, input bit sm, input int a, input int b, input logic [15:0] exp);
    int n, w;
    w = w8 ? 8 : 4;
    @(negedge clk);
    n = 0;
    while (get_busy(w8) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("idle_timeout", 16'h1, 16'h0);
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = 1; q8.push_back(exp); end
    else begin a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = 1; q4.push_back(exp); end
    @(posedge clk); #1;
    start4 = 0; start8 = 0;
    chk("busy_after_accept", {15'h0, get_busy(w8)}, 16'h1);
    chk("done_clear_on_accept", {15'h0, get_done(w8)}, 16'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!get_done(w8) && n < 30);
    chk("latency", n[15:0], 16'(w + 1));
    chk("busy_low_at_done", {15'h0, get_busy(w8)}, 16'h0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy4", {15'h0, busy4}, 16'h0);
    chk("rst_done4", {15'h0, done4}, 16'h0);
    chk("rst_res4", {8'h0, res4}, 16'h0);
    chk("rst_res8", res8, 16'h0);
    @(negedge clk); rst = 0;

    // Unsigned basics
    op(0, 0, 3, 2, 16'h06);
    op(0, 0, 15, 0, 16'h00);
    op(0, 0, 15, 15, 16'hE1);
    // Signed
    op(0, 1, 4'hD, 5, 16'hF1);
    op(0, 1, 8, 8, 16'h40);
    op(0, 1, 8, 7, 16'hC8);
    op(0, 1, 7, 4'hF, 16'hF9);
    op(0, 1, 0, 4'hF, 16'h00);

    // Start mid-RUN is ignored: result stays 25 and no extra operation runs
    @(negedge clk);
    a4 = 5; b4 = 5; sm4 = 0; start4 = 1; q4.push_back(16'd25);
    @(negedge clk); start4 = 0;
    @(negedge clk); @(negedge clk);
    a4 = 2; b4 = 3; start4 = 1;
    @(negedge clk); start4 = 0;
    n = 0;
    while (!done4 && n < 20) begin @(negedge clk); n++; end
    chk("ignored_start_res", {8'h0, res4}, 16'd25);
    repeat (3) @(negedge clk);
    chk("no_extra_op", {15'h0, busy4}, 16'h0);

    // Start held across done: back-to-back ops, done low WIDTH+1 cycles
    @(negedge clk);
    a4 = 3; b4 = 3; sm4 = 0; start4 = 1;
    q4.push_back(16'd9); q4.push_back(16'd9);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done4 && n < 30);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done4 && n < 30);
    start4 = 0;
    chk("b2b_done_low", 16'(n - 1), 16'd5);

    // Reset mid-RUN aborts, then a fresh op works
    @(negedge clk);
    n = 0;
    while (busy4 && n < 20) begin @(negedge clk); n++; end
    a4 = 7; b4 = 7; sm4 = 0; start4 = 1;
    @(negedge clk); start4 = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_busy", {15'h0, busy4}, 16'h0);
    chk("midrst_done", {15'h0, done4}, 16'h0);
    chk("midrst_res", {8'h0, res4}, 16'h0);
    @(negedge clk); rst = 0;
    op(0, 0, 4, 4, 16'd16);

    // WIDTH=8 boundaries
    op(1, 0, 255, 255, 16'hFE01);
    op(1, 1, 128, 128, 16'h4000);
    op(1, 1, 128, 127, model(8, 1, 128, 127));

    // Random
    for (int i = 0; i < 4000; i++) begin
      bit w8, sm;
      int a, b, w;
      w8 = i[1]; sm = i[0];
      w = w8 ? 8 : 4;
      a = $urandom_range((1 << w) - 1);
      b = $urandom_range((1 << w) - 1);
      op(w8, sm, a, b, model(w, sm, a, b));
    end

    repeat (4) @(negedge clk);
    chk("q4_drained", 16'(q4.size()), 16'h0);
    chk("q8_drained", 16'(q8.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
